priv_1_12_trap_sequencer: RTL and testbench
===========================================

// Module: priv_1_12_trap_sequencer
// PURPOSE
//  Sequences PC redirection for traps and MRET in the v1.12 privilege block (pipe_ctrl role).
//  Sees a trap (intr) or return (mret) and requests a pipeline drain until pipe_clear.
//  Then computes the target from mtvec/mcause or mepc and pulses insert_pc with priv_pc for one cycle.
//  M-mode only: sret/uret are never sequenced; they reach int_ex_handler as illegal instructions.
// PARAMETERS
//  FLUSH_TIMEOUT  64  DRAIN cycles without pipe_clear before timeout_err sets; 0 disables the check
// PORTS
//  CLK          in   1   clock, all state updates on rising edge
//  nRST         in   1   asynchronous active-low reset
//  intr         in   1   trap pending from int_ex_handler (level)
//  mret         in   1   MRET in the commit stage (level)
//  pipe_clear   in   1   pipeline free of hazards/in-flight ops
//  curr_mtvec   in   32  [31:2] BASE, [1:0] MODE
//  curr_mcause  in   32  [31] interrupt flag, [30:0] cause code
//  curr_mepc    in   32  return address
//  flush_req    out  1   asks pipeline to drain/squash younger instrs
//  busy         out  1   sequencer not IDLE
//  insert_pc    out  1   one-cycle redirect strobe
//  priv_pc      out  32  redirect target; valid when insert_pc=1, holds last value otherwise
//  timeout_err  out  1   sticky: drain exceeded FLUSH_TIMEOUT
// BEHAVIOUR
//  Reset (async, nRST=0): state=IDLE, kind=NONE, counter=0.
//   All outputs go to 0 immediately, including priv_pc and timeout_err.
//  FSM, one transition per CLK:
//   IDLE:    intr -> DRAIN, kind=TRAP; else mret -> DRAIN, kind=RET.
//            intr and mret together -> kind=TRAP (trap wins).
//   DRAIN:   flush_req=1, counter++; intr while kind=RET -> kind=TRAP (preempts return).
//            mret while kind=TRAP is ignored; pipe_clear=1 -> CALC, counter=0.
//   CALC:    priv_pc register loaded from curr_* sampled this cycle.
//            CSR injection done on the pipe_clear cycle is visible here.
//   INSERT:  insert_pc=1 for exactly this cycle -> RELEASE.
//   RELEASE: wait until intr=0 and mret=0 -> IDLE.
//            Prevents a held level from re-triggering.
//  busy=1 in every state except IDLE; flush_req=1 only in DRAIN.
//  Latency: event seen in IDLE at cycle 0 with pipe_clear=1 -> insert_pc at cycle 3 (minimum).
//   In general: INSERT is 2 cycles after the first DRAIN cycle with pipe_clear=1.
//  Target, TRAP:
//   MODE=00 direct -> {BASE,2'b00}.
//   MODE=01 vectored and mcause[31]=1 -> {BASE,2'b00} + (mcause[30:0]<<2), modulo 2^32 (wrap allowed).
//   MODE=01 with mcause[31]=0 -> {BASE,2'b00}.
//   MODE=1x reserved -> treated as direct.
//  Target, RET: {curr_mepc[31:2],2'b00} (IALIGN=32).
//  Timeout: counter saturates; when it reaches FLUSH_TIMEOUT in DRAIN, timeout_err<=1 (sticky until reset).
//   Sequencing continues; insert still occurs once pipe_clear arrives. FLUSH_TIMEOUT=0 -> never set.
//  Events arriving in CALC/INSERT/RELEASE are not queued.
//   They are re-evaluated in IDLE only after intr=0 and mret=0 have been seen once.
//  Exactly one insert_pc pulse per DRAIN entry; never two consecutive cycles.
// TESTING
//  T1 direct: mtvec=0x00001000, mcause=0x0000000B, intr=1, pipe_clear=1 at cyc0
//     -> flush_req cyc1, insert_pc=1 only cyc3, priv_pc=0x00001000
//  T2 vectored: mtvec=0x00002001, mcause=0x80000007 -> priv_pc=0x0000201C;
//     mcause=0x00000002 -> priv_pc=0x00002000; mtvec=0xFFFFFFFD, mcause=0x80000003 -> 0x00000008 (wrap)
//  T3 return: mret=1, mepc=0x00004006 -> priv_pc=0x00004004, one insert_pc
//  T4 drain/timeout: FLUSH_TIMEOUT=8, intr=1, pipe_clear=0 for 12 cycles
//     -> flush_req held, no insert, timeout_err=1 from 8th DRAIN cycle;
//     pipe_clear=1 -> insert 2 cycles later, timeout_err stays 1
//  T5 preempt: mret in IDLE, intr rises 2nd DRAIN cycle, mtvec=0x1000, mepc=0x4000
//     -> single insert_pc with priv_pc=0x00001000
//  T6 reset/hold: nRST=0 mid-DRAIN -> all outputs 0 same cycle;
//     after insert with intr held 5 cycles -> no 2nd insert until intr drops and rises again

Source files
------------

// File: rtl/priv_1_12_trap_sequencer.sv
// priv_1_12_trap_sequencer
//   Sequences the PC redirect for M-mode traps and MRET. A trap (intr) or
//   return (mret) seen in IDLE starts a pipeline drain; once the pipeline
//   reports pipe_clear the target is computed from mtvec/mcause (trap) or
//   mepc (return) and presented on priv_pc with a one-cycle insert_pc strobe.
//   sret/uret are not sequenced here; they are illegal instructions upstream.
//
// Ports
//   CLK, nRST      clock (rising edge), asynchronous active-low reset
//   intr           trap pending (level)
//   mret           MRET in commit stage (level)
//   pipe_clear     pipeline has no hazards / in-flight ops
//   curr_mtvec     [31:2] BASE, [1:0] MODE
//   curr_mcause    [31] interrupt flag, [30:0] cause code
//   curr_mepc      return address
//   flush_req      drain request, high only while draining
//   busy           sequencer not idle
//   insert_pc      one-cycle redirect strobe
//   priv_pc        redirect target, held between strobes
//   timeout_err    sticky drain-timeout flag
//   state_dbg      current FSM state (for checkers)
//
// Handshake: insert_pc is a pure strobe with no back-pressure. priv_pc is
// valid in the cycle insert_pc=1 and holds its value afterwards; the consumer
// must take the redirect in that single cycle.

module priv_1_12_trap_sequencer #(
  parameter int unsigned FLUSH_TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        intr,
  input  logic        mret,
  input  logic        pipe_clear,
  input  logic [31:0] curr_mtvec,
  input  logic [31:0] curr_mcause,
  input  logic [31:0] curr_mepc,
  output logic        flush_req,
  output logic        busy,
  output logic        insert_pc,
  output logic [31:0] priv_pc,
  output logic        timeout_err,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DRAIN   = 3'd1;
  localparam logic [2:0] S_CALC    = 3'd2;
  localparam logic [2:0] S_INSERT  = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_TRAP = 2'd1;
  localparam logic [1:0] K_RET  = 2'd2;

  localparam bit TIMEOUT_EN = (FLUSH_TIMEOUT != 0);
  localparam int unsigned CW = TIMEOUT_EN ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = TIMEOUT_EN ? CW'(FLUSH_TIMEOUT) : '0;

  logic [2:0]    state, state_nxt;
  logic [1:0]    kind, kind_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          set_timeout;

  logic [31:0] vec_base;
  logic [31:0] vec_off;
  logic [31:0] trap_pc;
  logic [31:0] ret_pc;

  // mcause[30] shifts out of a 32-bit target; mepc[1:0] are forced to zero.
  logic unused_bits;
  assign unused_bits = &{1'b0, curr_mcause[30], curr_mepc[1:0]};

  always_comb begin
    vec_base = {curr_mtvec[31:2], 2'b00};
    vec_off  = {curr_mcause[29:0], 2'b00};
    // Only MODE=01 with an interrupt cause vectors; reserved modes act direct.
    if (curr_mtvec[1:0] == 2'b01 && curr_mcause[31]) begin
      trap_pc = vec_base + vec_off;
    end else begin
      trap_pc = vec_base;
    end
    ret_pc = {curr_mepc[31:2], 2'b00};
  end

  always_comb begin
    state_nxt   = state;
    kind_nxt    = kind;
    cnt_nxt     = cnt;
    set_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (intr) begin
          state_nxt = S_DRAIN;
          kind_nxt  = K_TRAP;
        end else if (mret) begin
          state_nxt = S_DRAIN;
          kind_nxt  = K_RET;
        end
      end
      S_DRAIN: begin
        // A trap preempts a pending return; mret never downgrades a trap.
        if (intr && kind == K_RET) begin
          kind_nxt = K_TRAP;
        end
        if (pipe_clear) begin
          state_nxt = S_CALC;
          cnt_nxt   = '0;
        end else begin
          // cnt counts completed DRAIN cycles without pipe_clear, saturating.
          cnt_nxt     = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
          set_timeout = TIMEOUT_EN && (cnt_nxt == CNT_MAX);
        end
      end
      S_CALC:   state_nxt = S_INSERT;
      S_INSERT: state_nxt = S_RELEASE;
      S_RELEASE: begin
        // Held levels must drop before a new event can be accepted.
        if (!intr && !mret) begin
          state_nxt = S_IDLE;
          kind_nxt  = K_NONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        kind_nxt  = K_NONE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= S_IDLE;
      kind        <= K_NONE;
      cnt         <= '0;
      priv_pc     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      kind  <= kind_nxt;
      cnt   <= cnt_nxt;
      // CSR values written on the pipe_clear cycle are already visible here.
      if (state == S_CALC) begin
        priv_pc <= (kind == K_TRAP) ? trap_pc : ret_pc;
      end
      if (set_timeout) begin
        timeout_err <= 1'b1;
      end
    end
  end

  assign flush_req = (state == S_DRAIN);
  assign busy      = (state != S_IDLE);
  assign insert_pc = (state == S_INSERT);
  assign state_dbg = state;

endmodule

// File: tb/tb_priv_1_12_trap_sequencer.sv
// tb_priv_1_12_trap_sequencer
//   Directed bench for priv_1_12_trap_sequencer (FLUSH_TIMEOUT=8). Stimulus
//   pushes the expected redirect target into exp_q; a negedge monitor pops
//   and compares on every insert_pc strobe.

module tb_priv_1_12_trap_sequencer;

  logic        CLK;
  logic        nRST;
  logic        intr;
  logic        mret;
  logic        pipe_clear;
  logic [31:0] curr_mtvec;
  logic [31:0] curr_mcause;
  logic [31:0] curr_mepc;
  logic        flush_req;
  logic        busy;
  logic        insert_pc;
  logic [31:0] priv_pc;
  logic        timeout_err;
  logic [2:0]  state_dbg;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic        prev_insert = 1'b0;

  priv_1_12_trap_sequencer #(.FLUSH_TIMEOUT(8)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .intr       (intr),
    .mret       (mret),
    .pipe_clear (pipe_clear),
    .curr_mtvec (curr_mtvec),
    .curr_mcause(curr_mcause),
    .curr_mepc  (curr_mepc),
    .flush_req  (flush_req),
    .busy       (busy),
    .insert_pc  (insert_pc),
    .priv_pc    (priv_pc),
    .timeout_err(timeout_err),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin
    if (insert_pc === 1'b1) begin
      checks++;
      if (prev_insert) begin
        errors++;
        $display("FAIL insert_twice: insert_pc high on consecutive cycles got 1 expected 0");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_insert: priv_pc=0x%08h got insert expected none", priv_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (priv_pc !== e) begin
          errors++;
          $display("FAIL priv_pc: got 0x%08h expected 0x%08h", priv_pc, e);
        end
      end
    end
    prev_insert = (insert_pc === 1'b1);
  end

  // Event with pipe_clear already high: insert 3 cycles after IDLE sees it.
  // hold = cycles the event level stays high after the insert cycle.
  task automatic fast_event(input string nm, input logic t, input logic r,
                            input logic [31:0] exp_pc, input int hold);
    exp_q.push_back(exp_pc);
    intr = t;
    mret = r;
    pipe_clear = 1'b1;
    check({nm, "_idle_flush"}, 32'(flush_req), 32'd0);
    tick();
    check({nm, "_drain_flush"}, 32'(flush_req), 32'd1);
    check({nm, "_drain_busy"}, 32'(busy), 32'd1);
    tick();
    check({nm, "_calc_noins"}, 32'({flush_req, insert_pc}), 32'd0);
    tick();
    check({nm, "_insert"}, 32'(insert_pc), 32'd1);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({nm, "_hold_noins"}, 32'(insert_pc), 32'd0);
      check({nm, "_hold_state"}, 32'(state_dbg), 32'd4);
    end
    intr = 1'b0;
    mret = 1'b0;
    tick();
    tick();
    check({nm, "_back_idle"}, 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nRST = 1'b0;
    intr = 1'b0;
    mret = 1'b0;
    pipe_clear = 1'b0;
    curr_mtvec = '0;
    curr_mcause = '0;
    curr_mepc = '0;
    repeat (3) tick();
    check("reset_outputs", {26'd0, flush_req, busy, insert_pc, timeout_err, 2'b00}, 32'd0);
    check("reset_priv_pc", priv_pc, 32'd0);
    nRST = 1'b1;
    tick();

    // T1 direct
    curr_mtvec = 32'h0000_1000;
    curr_mcause = 32'h0000_000B;
    fast_event("t1", 1'b1, 1'b0, 32'h0000_1000, 0);

    // T2 vectored, sync cause in vectored mode, wrap-around
    curr_mtvec = 32'h0000_2001;
    curr_mcause = 32'h8000_0007;
    fast_event("t2a", 1'b1, 1'b0, 32'h0000_201C, 0);
    curr_mcause = 32'h0000_0002;
    fast_event("t2b", 1'b1, 1'b0, 32'h0000_2000, 0);
    curr_mtvec = 32'hFFFF_FFFD;
    curr_mcause = 32'h8000_0003;
    fast_event("t2c", 1'b1, 1'b0, 32'h0000_0008, 0);
    // Reserved MODE=1x behaves as direct
    curr_mtvec = 32'h0000_3002;
    curr_mcause = 32'h8000_0005;
    fast_event("t2d", 1'b1, 1'b0, 32'h0000_3000, 0);

    // T3 return, mepc low bits dropped; intr and mret together: trap wins
    curr_mepc = 32'h0000_4006;
    fast_event("t3", 1'b0, 1'b1, 32'h0000_4004, 0);
    curr_mtvec = 32'h0000_1000;
    curr_mcause = 32'h0000_000B;
    fast_event("t3_both", 1'b1, 1'b1, 32'h0000_1000, 0);

    // T4 drain timeout
    curr_mtvec = 32'h0000_3000;
    curr_mcause = 32'h0000_0001;
    pipe_clear = 1'b0;
    intr = 1'b1;
    exp_q.push_back(32'h0000_3000);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("t4_flush_held", 32'(flush_req), 32'd1);
      check("t4_no_insert", 32'(insert_pc), 32'd0);
      if (k <= 7) check("t4_no_timeout_yet", 32'(timeout_err), 32'd0);
      if (k >= 9) check("t4_timeout_set", 32'(timeout_err), 32'd1);
    end
    pipe_clear = 1'b1;
    tick();
    check("t4_calc", 32'(insert_pc), 32'd0);
    tick();
    check("t4_insert", 32'(insert_pc), 32'd1);
    check("t4_timeout_sticky", 32'(timeout_err), 32'd1);
    intr = 1'b0;
    tick();
    tick();
    check("t4_idle", 32'(busy), 32'd0);
    check("t4_timeout_still", 32'(timeout_err), 32'd1);

    // T5 mret preempted by intr in the 2nd DRAIN cycle
    curr_mtvec = 32'h0000_1000;
    curr_mepc = 32'h0000_4000;
    pipe_clear = 1'b0;
    mret = 1'b1;
    exp_q.push_back(32'h0000_1000);
    tick();
    check("t5_drain1", 32'(flush_req), 32'd1);
    tick();
    intr = 1'b1;
    pipe_clear = 1'b1;
    tick();
    check("t5_calc", 32'(flush_req), 32'd0);
    tick();
    check("t5_insert", 32'(insert_pc), 32'd1);
    intr = 1'b0;
    mret = 1'b0;
    tick();
    tick();
    check("t5_idle", 32'(busy), 32'd0);

    // T6 async reset mid-DRAIN
    pipe_clear = 1'b0;
    intr = 1'b1;
    tick();
    tick();
    check("t6_in_drain", 32'(flush_req), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    check("t6_reset_outputs", {26'd0, flush_req, busy, insert_pc, timeout_err, 2'b00}, 32'd0);
    check("t6_reset_priv_pc", priv_pc, 32'd0);
    intr = 1'b0;
    tick();
    nRST = 1'b1;
    tick();

    // T6 held intr after insert must not retrigger until it drops
    curr_mtvec = 32'h0000_5000;
    fast_event("t6_hold", 1'b1, 1'b0, 32'h0000_5000, 5);
    fast_event("t6_rearm", 1'b1, 1'b0, 32'h0000_5000, 0);

    repeat (3) tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
